// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
//   Shared definitions for the immediate-generator pipeline:
//     - imm_fmt_e   : resolved immediate format codes (I/S/B/U/J/R + reserved)
//     - OPC_*       : RV32I major opcodes recognised by the auto decoder
//     - F3_*        : funct3 values selecting the immediate-shift forms
//     - xlen_legal(): elaboration-time legality check for the XLEN parameter
// -----------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_R    = 3'd5,
    FMT_RSV6 = 3'd6,
    FMT_RSV7 = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 of slli and srli/srai inside OP-IMM
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
//   Purely combinational immediate extractor.
//   Parameters:
//     XLEN        - width of the extended immediate (32 or 64)
//     AUTO_DECODE - 1: format derived from the opcode, 0: taken from imm_src
//   Ports:
//     instr   in  [31:0]      raw RV32I instruction word
//     imm_src in  [2:0]       explicit format code (used only when AUTO_DECODE=0)
//     imm     out [XLEN-1:0]  sign-extended immediate (zero for R/illegal)
//     fmt     out [2:0]       resolved format code
//     illegal out             reserved format code or unmapped opcode
// -----------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  // Shift amounts are 5 bits on a 32-bit datapath, 6 bits on a 64-bit one.
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  imm_fmt_e    fmt_sel;
  logic        illegal_sel;
  logic [31:0] imm32;
  logic        is_shift;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Format resolution
  always_comb begin
    fmt_sel     = imm_fmt_e'(imm_src);
    illegal_sel = 1'b0;
    if (AUTO_DECODE != 0) begin
      unique case (opcode)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt_sel = FMT_I;
        OPC_STORE:                                  fmt_sel = FMT_S;
        OPC_BRANCH:                                 fmt_sel = FMT_B;
        OPC_LUI, OPC_AUIPC:                         fmt_sel = FMT_U;
        OPC_JAL:                                    fmt_sel = FMT_J;
        OPC_OP:                                     fmt_sel = FMT_R;
        default: begin
          // Unmapped opcode reports a reserved code so downstream never
          // mistakes it for a real format.
          fmt_sel     = FMT_RSV7;
          illegal_sel = 1'b1;
        end
      endcase
    end else begin
      illegal_sel = (imm_src == FMT_RSV6) || (imm_src == FMT_RSV7);
    end
  end

  // Raw 32-bit immediate; widened to XLEN below with sign extension.
  always_comb begin
    imm32 = 32'h0000_0000;
    unique case (fmt_sel)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'h000};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = 32'h0000_0000;
    endcase
  end

  // slli/srli/srai: the upper I-immediate bits are funct7, not part of the
  // value, so only the zero-extended shift amount is produced.
  assign is_shift = (fmt_sel == FMT_I) && (opcode == OPC_OP_IMM) &&
                    ((funct3 == F3_SLLI) || (funct3 == F3_SRXI));

  always_comb begin
    if (is_shift) begin
      imm = XLEN'(instr[20 +: SHW]);
    end else begin
      imm = XLEN'($signed(imm32));
    end
  end

  assign fmt     = fmt_sel;
  assign illegal = illegal_sel;

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator with a valid/ready handshake on both sides.
//   A combinational imm_decode feeds a two-entry buffer: the output register
//   plus a skid register that absorbs one result when the consumer stalls,
//   allowing a fully registered in_ready.
//   Parameters:
//     XLEN        - output immediate width (32 or 64)
//     AUTO_DECODE - 1: format from opcode, 0: format from in_imm_src
//   Ports:
//     clk         in              clock, all state on the rising edge
//     rst_n       in              asynchronous active-low reset
//     in_valid    in              in_instr / in_imm_src valid
//     in_ready    out             input accepted this cycle (registered)
//     in_instr    in  [31:0]      raw instruction word
//     in_imm_src  in  [2:0]       explicit format code
//     out_valid   out             out_* valid
//     out_ready   in              consumer accepts output this cycle
//     out_imm     out [XLEN-1:0]  extended immediate
//     out_fmt     out [2:0]       resolved format code
//     out_illegal out             unsupported opcode / format code
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Decoder
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Buffer state
  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_imm_q,     out_imm_d;
  logic [2:0]      out_fmt_q,     out_fmt_d;
  logic            out_illegal_q, out_illegal_d;

  logic            skid_valid_q,   skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,     skid_imm_d;
  logic [2:0]      skid_fmt_q,     skid_fmt_d;
  logic            skid_illegal_q, skid_illegal_d;

  logic            in_ready_q, in_ready_d;

  logic            in_fire;
  logic            out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;

    if (!out_valid_q || out_fire) begin
      // Output register is free at this edge. The skid entry is older than
      // anything arriving now, so it goes first. in_ready is low whenever the
      // skid is full, so a new input never competes with a skid drain.
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (in_fire) begin
        out_valid_d   = 1'b1;
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: park the new result behind it.
      skid_valid_d   = 1'b1;
      skid_imm_d     = dec_imm;
      skid_fmt_d     = dec_fmt;
      skid_illegal_d = dec_illegal;
    end

    // Registered ready: accept next cycle only if the skid will be empty.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= 3'd0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= 3'd0;
      skid_illegal_q <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. Three instances share clock, reset and
//   input stimulus: a default 32-bit auto-decode instance, a 64-bit
//   auto-decode instance and a 32-bit explicit-format instance.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [63:0] w_out_imm;
  logic [2:0]  w_out_fmt;

  logic        m_in_ready, m_out_valid, m_out_illegal;
  logic [31:0] m_out_imm;
  logic [2:0]  m_out_fmt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
    .out_illegal(w_out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) dut_man (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_imm(m_out_imm), .out_fmt(m_out_fmt),
    .out_illegal(m_out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input for exactly one edge; caller ensures in_ready is high.
  task automatic xfer(input logic [31:0] instr, input logic [2:0] src);
    in_instr   = instr;
    in_imm_src = src;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    $display("xfer instr=0x%08h src=%0d -> out_valid=%0b imm=0x%0h fmt=%0d ill=%0b in_ready=%0b",
             instr, src, a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_in_ready);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = 32'h0;
    in_imm_src = 3'd0;
    out_ready  = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid",   a_out_valid,   0);
    chk("rst_out_imm",     a_out_imm,     0);
    chk("rst_out_fmt",     a_out_fmt,     0);
    chk("rst_out_illegal", a_out_illegal, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready",    a_in_ready,    1);
    chk("rst_idle_valid",  a_out_valid,   0);

    // addi x1,x0,-1 : one cycle after transfer
    xfer(32'hFFF00093, 3'd0);
    chk("addi_valid",   a_out_valid,   1);
    chk("addi_imm",     a_out_imm,     64'hFFFF_FFFF);
    chk("addi_fmt",     a_out_fmt,     0);
    chk("addi_illegal", a_out_illegal, 0);
    chk("addi_imm64",   w_out_imm,     64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("addi_drained", a_out_valid,   0);

    // Back-to-back stream, out_ready=1: one result per cycle
    xfer(32'hFE112E23, 3'd0);
    chk("sw_imm", a_out_imm, 64'hFFFF_FFFC);
    chk("sw_fmt", a_out_fmt, 1);
    xfer(32'hFE000CE3, 3'd0);
    chk("beq_valid", a_out_valid, 1);
    chk("beq_imm",   a_out_imm,   64'hFFFF_FFF8);
    chk("beq_fmt",   a_out_fmt,   2);
    xfer(32'h001000EF, 3'd0);
    chk("jal_imm", a_out_imm, 64'h0000_0800);
    chk("jal_fmt", a_out_fmt, 4);
    xfer(32'h4030D093, 3'd0);
    chk("srai_imm",   a_out_imm, 64'h3);
    chk("srai_imm64", w_out_imm, 64'h3);
    // bit 25 belongs to shamt only on the 64-bit datapath
    xfer(32'h4230D093, 3'd0);
    chk("srai35_imm32", a_out_imm, 64'h3);
    chk("srai35_imm64", w_out_imm, 64'd35);
    xfer(32'h123452B7, 3'd0);
    chk("lui_imm", a_out_imm, 64'h1234_5000);
    chk("lui_fmt", a_out_fmt, 3);
    xfer(32'h800002B7, 3'd0);
    chk("lui_neg_imm32", a_out_imm, 64'h8000_0000);
    chk("lui_neg_imm64", w_out_imm, 64'hFFFF_FFFF_8000_0000);
    xfer(32'h002081B3, 3'd0);
    chk("add_imm",     a_out_imm,     0);
    chk("add_fmt",     a_out_fmt,     5);
    chk("add_illegal", a_out_illegal, 0);
    // Unmapped opcode (auto) and reserved code 7 (explicit)
    xfer(32'h00000000, 3'd7);
    chk("opc0_illegal", a_out_illegal, 1);
    chk("opc0_imm",     a_out_imm,     0);
    chk("man7_illegal", m_out_illegal, 1);
    chk("man7_imm",     m_out_imm,     0);
    chk("man7_fmt",     m_out_fmt,     7);
    // Explicit S format overrides an unrelated opcode
    xfer(32'hFE112E13, 3'd1);
    chk("man_s_imm",     m_out_imm,     64'hFFFF_FFFC);
    chk("man_s_illegal", m_out_illegal, 0);
    tick();
    chk("stream_drained", a_out_valid, 0);

    // Stall: out_ready=0 while streaming A,B,C
    out_ready = 1'b0;
    xfer(32'h00100093, 3'd0);
    chk("stall_a_imm",   a_out_imm,  1);
    chk("stall_a_ready", a_in_ready, 1);
    xfer(32'h00200093, 3'd0);
    chk("stall_b_ready", a_in_ready, 0);
    chk("stall_b_hold",  a_out_imm,  1);
    in_instr = 32'h00300093;
    in_valid = 1'b1;
    tick();
    chk("stall_c_hold",  a_out_imm,  1);
    chk("stall_c_valid", a_out_valid, 1);
    chk("stall_c_ready", a_in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("release_b_imm",   a_out_imm,  2);
    chk("release_b_ready", a_in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("release_c_imm",   a_out_imm,   3);
    chk("release_c_valid", a_out_valid, 1);
    tick();
    chk("release_empty",   a_out_valid, 0);

    // Reset with both entries full
    out_ready = 1'b0;
    xfer(32'h00700093, 3'd0);
    xfer(32'h00800093, 3'd0);
    chk("full_ready", a_in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_imm",   a_out_imm,   0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("postrst_ready", a_in_ready,  1);
    chk("postrst_idle",  a_out_valid, 0);
    xfer(32'h00500093, 3'd0);
    chk("postrst_first", a_out_imm, 5);
    tick();
    chk("postrst_no_stale", a_out_valid, 0);
    tick();
    chk("postrst_no_stale2", a_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter AUTO_DECODE, default 1; 1 derives format from opcode, 0 uses in_imm_src.
REQ-003 SHALL have port clk  input  1  the single clock; all state rises on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_instr/in_imm_src are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_instr  input  32  raw RV32I instruction word.
REQ-008 SHALL have port in_imm_src  input  3  explicit format; ignored when AUTO_DECODE=1.
REQ-009 SHALL have port out_valid  output  1  out_* fields are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts output this cycle.
REQ-011 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-012 SHALL have port out_fmt  output  3  resolved format code.
REQ-013 SHALL have port out_illegal  output  1  opcode or format code unsupported.

Function
REQ-014 SHALL use format codes 0=I, 1=S, 2=B, 3=U, 4=J, 5=R (no immediate), 6-7 reserved.
REQ-015 SHALL build immediates: I={sx,instr[31:20]}; S={sx,instr[31:25],instr[11:7]}; B={sx,instr[31],instr[7],instr[30:25],instr[11:8],0}; U={sx,instr[31:12],12'h000}; J={sx,instr[31],instr[19:12],instr[20],instr[30:21],0}; sx replicates instr[31] up to XLEN.
REQ-016 SHALL, in auto mode, map opcodes 0010011/0000011/1100111/1110011->I, 0100011->S, 1100011->B, 0110111/0010111->U, 1101111->J, 0110011->R.
REQ-017 SHALL, for opcode 0010011 with funct3 001 or 101, output zero-extended shamt (instr[24:20] at XLEN=32, instr[25:20] at XLEN=64), not the funct7 bits.
REQ-018 SHALL output out_imm=0 for R, reserved codes and unmapped opcodes; out_illegal=1 for reserved codes and unmapped opcodes only.
REQ-019 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready.
REQ-020 SHALL register results: latency exactly 1 cycle from input transfer to out_valid with empty buffer; throughput 1 per cycle when out_ready=1.
REQ-021 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL contain a 2-entry buffer (output register + skid register); in_ready is registered, =1 when the skid register is empty.
REQ-023 SHALL, on input transfer while output stalled, store the result in the skid register; in_ready falls next cycle.
REQ-024 SHALL, on output transfer with skid full, move skid to output in the same edge and reassert in_ready next cycle.
REQ-025 SHALL, on simultaneous input and output transfer with skid empty, load the new result into the output register with no bubble.
REQ-026 SHALL preserve strict FIFO order; no result dropped or duplicated.

Reset
REQ-027 SHALL, while rst_n=0, clear both entries: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, in_ready=1 after release.
REQ-028 SHALL discard in-flight results on reset assertion mid-operation; first post-reset output is the first post-reset input.

Structure
REQ-029 SHALL take format codes, opcode constants and XLEN legality check from shared package imm_pkg.
REQ-030 SHALL use one combinational sub-module imm_decode (instr, imm_src -> imm, fmt, illegal) feeding the buffer logic.

Verification
REQ-031 SHALL check: 0xFFF00093 (addi -1) -> out_imm=0xFFFFFFFF, fmt=0, one cycle after transfer.
REQ-032 SHALL check: 0xFE112E23 -> 0xFFFFFFFC fmt=1; 0xFE000CE3 -> 0xFFFFFFF8 fmt=2; 0x001000EF -> 0x00000800 fmt=4.
REQ-033 SHALL check: 0x4030D093 (srai 3) -> out_imm=0x00000003; 0x123452B7 -> 0x12345000; XLEN=64 0x800002B7 -> 0xFFFFFFFF80000000.
REQ-034 SHALL check: opcode 0000000 -> out_illegal=1, out_imm=0; AUTO_DECODE=0 with in_imm_src=7 -> out_illegal=1.
REQ-035 SHALL check: out_ready=0 for 3 cycles while streaming A,B,C -> in_ready=0 after A,B accepted; release -> A,B,C in order, no loss.
REQ-036 SHALL check: rst_n pulsed low with both entries full -> out_valid=0 immediately, in_ready=1 after release, stale results never appear.
